// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// uart_rx_cfg: configurable UART receiver (5-8 data bits, optional odd/even
// parity, one or two stop bits). OVS-times oversampling, 2-of-3 majority vote
// per bit, and a one-deep output holding register with ready/valid handshake.
module uart_rx_cfg #(
    parameter int OVS         = 16,  // even, 8..64
    parameter int SYNC_STAGES = 2    // 2 or more
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [1:0] data_bits,
    input  logic       parity_en,
    input  logic       odd_even_parity,
    input  logic       stop_bits,
    input  logic       sin,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       overrun_err,
    output logic       busy
);
    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] SMP0 = CW'(OVS/2 - 1);
    localparam logic [CW-1:0] SMP1 = CW'(OVS/2);
    localparam logic [CW-1:0] SMP2 = CW'(OVS/2 + 1);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sin_s, sin_prev_q;
    logic [1:0]             smp_q;
    logic                   vote;
    logic [1:0]             cfg_bits_q;
    logic                   cfg_par_en_q, cfg_odd_q, cfg_two_stop_q;
    logic [7:0]             shift_q;
    logic                   par_acc_q, zero_q, perr_q;
    logic                   start_det, frame_done, brk_now;
    logic                   at_vote, at_end, last_data, last_stop;

    // Bring the asynchronous line into the clk domain; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
    end

    assign sin_s     = sync_q[SYNC_STAGES-1];
    // Third sample is taken live at SMP2, so the vote is ready on that tick.
    assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & sin_s) | (smp_q[1] & sin_s);
    assign at_vote   = (tick_cnt_q == SMP2);
    assign at_end    = (tick_cnt_q == LAST);
    assign last_data = (bit_cnt_q == ({1'b0, cfg_bits_q} + 3'd4));
    assign last_stop = !cfg_two_stop_q || (bit_cnt_q == 3'd1);
    assign brk_now   = ~vote & (bit_cnt_q == 3'd0) & zero_q;
    assign busy      = (state_q != IDLE);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values.
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Next-state, counter and frame-completion logic; nothing moves without baud_tick.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        start_det  = 1'b0;
        frame_done = 1'b0;
        if (baud_tick) begin
            tick_cnt_d = at_end ? '0 : tick_cnt_q + CW'(1);
            unique case (state_q)
                IDLE: begin
                    tick_cnt_d = '0;
                    if (sin_prev_q && !sin_s) begin
                        state_d   = START;
                        start_det = 1'b1;
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state_d    = IDLE;   // false start
                        tick_cnt_d = '0;
                    end else if (at_end) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    if (at_end) begin
                        if (last_data) begin
                            state_d   = cfg_par_en_q ? PARITY : STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (at_end) state_d = STOP;
                end
                STOP: begin
                    // A low first stop bit ends the frame early; no second check.
                    if (at_vote && (!vote || last_stop)) begin
                        frame_done = 1'b1;
                        state_d    = vote ? IDLE : WAIT_IDLE;
                        tick_cnt_d = '0;
                    end else if (at_end) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                WAIT_IDLE: begin
                    tick_cnt_d = '0;
                    if (sin_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sampling, per-frame config capture and data/parity/break accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too; cheap here and keeps them defined.
            sin_prev_q     <= 1'b1;
            smp_q          <= '0;
            cfg_bits_q     <= '0;
            cfg_par_en_q   <= 1'b0;
            cfg_odd_q      <= 1'b0;
            cfg_two_stop_q <= 1'b0;
            shift_q        <= '0;
            par_acc_q      <= 1'b0;
            zero_q         <= 1'b1;
            perr_q         <= 1'b0;
        end else if (baud_tick) begin
            sin_prev_q <= sin_s;
            if (tick_cnt_q == SMP0) smp_q[0] <= sin_s;
            if (tick_cnt_q == SMP1) smp_q[1] <= sin_s;
            if (start_det) begin
                cfg_bits_q     <= data_bits;
                cfg_par_en_q   <= parity_en;
                cfg_odd_q      <= odd_even_parity;
                cfg_two_stop_q <= stop_bits;
                shift_q        <= '0;
                par_acc_q      <= 1'b0;
                zero_q         <= 1'b1;
                perr_q         <= 1'b0;
            end else if (at_vote) begin
                if (state_q == DATA) begin
                    shift_q[bit_cnt_q] <= vote;
                    par_acc_q          <= par_acc_q ^ vote;
                    zero_q             <= zero_q & ~vote;
                end else if (state_q == PARITY) begin
                    perr_q <= par_acc_q ^ vote ^ cfg_odd_q;
                    zero_q <= zero_q & ~vote;
                end
            end
        end
    end

    // Output holding register: ready/valid handshake plus sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (frame_done && rx_valid && !rx_ready) begin
            overrun_err <= 1'b1;   // new frame dropped, held frame untouched
        end else if (frame_done) begin
            rx_data    <= shift_q;
            rx_valid   <= 1'b1;
            parity_err <= perr_q;
            frame_err  <= ~vote;
            break_det  <= brk_now;
            if (rx_valid) overrun_err <= 1'b0;   // old frame accepted this cycle
        end else if (rx_valid && rx_ready) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// tb_uart_rx_cfg: directed frames against uart_rx_cfg with hand-computed results.
module tb_uart_rx_cfg;
    localparam int OVS  = 16;
    localparam int TDIV = 4;   // clk cycles per baud_tick

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [1:0] data_bits = 2'd3;
    logic       parity_en = 1'b0;
    logic       odd_even_parity = 1'b0;
    logic       stop_bits = 1'b0;
    logic       sin = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, break_det, overrun_err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_cfg #(.OVS(OVS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_bits(data_bits),
        .parity_en(parity_en), .odd_even_parity(odd_even_parity), .stop_bits(stop_bits),
        .sin(sin), .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // baud_tick: one cycle in every TDIV, changed on the falling edge
    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            baud_tick = (div == TDIV - 1);
            div = (div == TDIV - 1) ? 0 : div + 1;
        end
    end

    // Cycle counter and cycle of the most recent sampled baud_tick
    int cyc = 0;
    int last_tick_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (baud_tick) last_tick_cyc <= cyc + 1;
    end

    // Output monitor: counts rx_valid rises and captures the frame at each rise
    int         valid_count = 0;
    int         valid_cycles = 0;
    int         busy_cycles = 0;
    int         rise_gap = -1;
    logic       prev_valid = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic [2:0] cap_flags = 3'b000;   // {parity_err, frame_err, break_det}
    always @(negedge clk) begin
        prev_valid <= rx_valid;
        if (rx_valid) valid_cycles <= valid_cycles + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (rx_valid && !prev_valid) begin
            valid_count <= valid_count + 1;
            cap_data    <= rx_data;
            cap_flags   <= {parity_err, frame_err, break_det};
            rise_gap    <= cyc - last_tick_cyc;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (baud_tick) k++;
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        @(negedge clk);
        sin = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                              input logic par_bit, input logic st1, input logic st2,
                              input logic two_stop);
        send_bit(1'b0, OVS);
        for (int i = 0; i < nbits; i++) send_bit(d[i], OVS);
        if (has_par) send_bit(par_bit, OVS);
        send_bit(st1, OVS);
        if (two_stop) send_bit(st2, OVS);
    endtask

    task automatic set_cfg(input logic [1:0] b, input logic pen, input logic odd, input logic st);
        @(negedge clk);
        data_bits = b;
        parity_en = pen;
        odd_even_parity = odd;
        stop_bits = st;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_data: got %h want 00", rx_data);
        end
        n_cmp++;
        if ({rx_valid, parity_err, frame_err, break_det, overrun_err, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {rx_valid, parity_err, frame_err, break_det, overrun_err, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(8);
        settle();
        n_cmp++;
        if ({rx_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL reset_idle: valid/busy got %b want 00", {rx_valid, busy});
        end
    endtask

    task automatic test_8n1();
        int vc0 = valid_count;
        int vcy0 = valid_cycles;
        int bc0 = busy_cycles;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        send_frame(8'h4D, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 8);
        settle();
        n_cmp++;
        if (valid_count - vc0 !== 1) begin
            n_bad++; $display("FAIL 8n1_count: got %0d want 1", valid_count - vc0);
        end
        n_cmp++;
        if (cap_data !== 8'h4D) begin
            n_bad++; $display("FAIL 8n1_data: got %h want 4d", cap_data);
        end
        n_cmp++;
        if (cap_flags !== 3'b000) begin
            n_bad++; $display("FAIL 8n1_flags: got %b want 000", cap_flags);
        end
        n_cmp++;
        if (valid_cycles - vcy0 !== 1) begin
            n_bad++; $display("FAIL 8n1_pulse: valid cycles got %0d want 1", valid_cycles - vcy0);
        end
        n_cmp++;
        if (rise_gap !== 0) begin
            n_bad++; $display("FAIL 8n1_latency: cycles after tick got %0d want 0", rise_gap);
        end
        n_cmp++;
        if ((busy_cycles - bc0 > 0) !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL 8n1_busy: busy cycles %0d now %b want >0 and 0",
                              busy_cycles - bc0, busy);
        end
    endtask

    task automatic test_parity();
        // 5-bit 0x15 (three ones), even parity, wrong parity bit 0
        set_cfg(2'd0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 8);
        settle();
        n_cmp++;
        if ({cap_data, cap_flags} !== {8'h15, 3'b100}) begin
            n_bad++; $display("FAIL par_even_bad: got %h/%b want 15/100", cap_data, cap_flags);
        end
        // same data, odd parity, parity bit 0 is correct
        set_cfg(2'd0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 8);
        settle();
        n_cmp++;
        if ({cap_data, cap_flags} !== {8'h15, 3'b000}) begin
            n_bad++; $display("FAIL par_odd_ok: got %h/%b want 15/000", cap_data, cap_flags);
        end
        // 6-bit 0x2A (three ones), even parity, parity bit 1 is correct
        set_cfg(2'd1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h2A, 6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 8);
        settle();
        n_cmp++;
        if ({cap_data, cap_flags} !== {8'h2A, 3'b000}) begin
            n_bad++; $display("FAIL par_6bit: got %h/%b want 2a/000", cap_data, cap_flags);
        end
    endtask

    task automatic test_cfg_capture();
        int vc0 = valid_count;
        logic [7:0] d = 8'hC3;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, OVS);
        set_cfg(2'd0, 1'b1, 1'b1, 1'b1);   // must not affect the frame in flight
        for (int i = 0; i < 8; i++) send_bit(d[i], OVS);
        send_bit(1'b1, OVS);
        send_bit(1'b1, 8);
        settle();
        n_cmp++;
        if (valid_count - vc0 !== 1 || cap_data !== 8'hC3 || cap_flags !== 3'b000) begin
            n_bad++; $display("FAIL cfg_capture: count %0d data %h flags %b want 1 c3 000",
                              valid_count - vc0, cap_data, cap_flags);
        end
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_8n2_frame_err();
        int vc0 = valid_count;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 2 * OVS);   // line stays low after the bad stop bit
        settle();
        n_cmp++;
        if (valid_count - vc0 !== 1 || cap_data !== 8'h3C || cap_flags !== 3'b010) begin
            n_bad++; $display("FAIL 8n2_ferr: count %0d data %h flags %b want 1 3c 010",
                              valid_count - vc0, cap_data, cap_flags);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL 8n2_wait_idle: busy got %b want 1", busy);
        end
        send_bit(1'b1, OVS);
        settle();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL 8n2_rearm: busy got %b want 0", busy);
        end
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 8);
        settle();
        n_cmp++;
        if (valid_count - vc0 !== 2 || cap_data !== 8'h5A || cap_flags !== 3'b000) begin
            n_bad++; $display("FAIL 8n2_good: count %0d data %h flags %b want 2 5a 000",
                              valid_count - vc0, cap_data, cap_flags);
        end
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_false_start();
        int vc0 = valid_count;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, OVS / 4);
        send_bit(1'b1, OVS);
        settle();
        n_cmp++;
        if (valid_count - vc0 !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL false_start: count %0d busy %b want 0 0",
                              valid_count - vc0, busy);
        end
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 8);
        settle();
        n_cmp++;
        if (valid_count - vc0 !== 1 || cap_data !== 8'hA5 || cap_flags !== 3'b000) begin
            n_bad++; $display("FAIL after_false_start: count %0d data %h flags %b want 1 a5 000",
                              valid_count - vc0, cap_data, cap_flags);
        end
    endtask

    task automatic test_overrun();
        @(negedge clk);
        rx_ready = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 4);
        settle();
        n_cmp++;
        if ({rx_valid, rx_data, overrun_err} !== {1'b1, 8'h11, 1'b0}) begin
            n_bad++; $display("FAIL ovr_first: valid %b data %h ovr %b want 1 11 0",
                              rx_valid, rx_data, overrun_err);
        end
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 4);
        settle();
        n_cmp++;
        if ({rx_valid, rx_data, overrun_err} !== {1'b1, 8'h11, 1'b1}) begin
            n_bad++; $display("FAIL ovr_second: valid %b data %h ovr %b want 1 11 1",
                              rx_valid, rx_data, overrun_err);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rx_valid, rx_data, overrun_err} !== {1'b0, 8'h00, 1'b0}) begin
            n_bad++; $display("FAIL ovr_accept: valid %b data %h ovr %b want 0 00 0",
                              rx_valid, rx_data, overrun_err);
        end
    endtask

    task automatic test_break();
        int vc0 = valid_count;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 20 * OVS);
        send_bit(1'b1, OVS);
        settle();
        n_cmp++;
        if (valid_count - vc0 !== 1 || cap_data !== 8'h00 || cap_flags !== 3'b011) begin
            n_bad++; $display("FAIL break: count %0d data %h flags %b want 1 00 011",
                              valid_count - vc0, cap_data, cap_flags);
        end
    endtask

    task automatic test_reset_mid_frame();
        int vc0;
        @(negedge clk);
        rx_ready = 1'b0;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 4);
        settle();
        n_cmp++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin
            n_bad++; $display("FAIL rst_pre_hold: valid %b data %h want 1 5a", rx_valid, rx_data);
        end
        send_bit(1'b0, OVS);
        send_bit(1'b1, OVS);
        send_bit(1'b1, OVS / 2);
        settle();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_busy: busy got %b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err, busy} !== 14'b0) begin
            n_bad++; $display("FAIL rst_mid: data %h flags %b want 00 000000", rx_data,
                              {rx_valid, parity_err, frame_err, break_det, overrun_err, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        vc0 = valid_count;
        send_bit(1'b1, 20 * OVS);
        settle();
        n_cmp++;
        if (valid_count - vc0 !== 0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_no_output: count %0d valid %b busy %b want 0 0 0",
                              valid_count - vc0, rx_valid, busy);
        end
        rx_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_cfg_capture();
        test_8n2_frame_err();
        test_false_start();
        test_overrun();
        test_break();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
